// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus fabric.
//   - bus_state_e   : transfer FSM encoding (IDLE / ACCESS / RESP)
//   - *_BASE/*_MASK : default memory map (GPIO, timer, UART, memory)
//   - SLV_*         : slave port index of each default peripheral
//   - idx_width()   : width of an encoded slave index for n slaves
package periph_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam logic [31:0] GPIO_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] TIMER_BASE = 32'hFFFF_1000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_F000;
  localparam logic [31:0] UART_BASE  = 32'hFFFF_2000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] MEM_BASE   = 32'h0000_0000;
  localparam logic [31:0] MEM_MASK   = 32'hFFFF_E000;

  localparam int SLV_GPIO  = 0;
  localparam int SLV_TIMER = 1;
  localparam int SLV_UART  = 2;
  localparam int SLV_MEM   = 3;

  // Flattened tables: slave i lives in bits [32*i+31:32*i].
  localparam logic [127:0] DEF_SLAVE_BASE = {MEM_BASE, UART_BASE, TIMER_BASE, GPIO_BASE};
  localparam logic [127:0] DEF_SLAVE_MASK = {MEM_MASK, UART_MASK, TIMER_MASK, GPIO_MASK};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational table-driven address decoder.
// Slave i hits when (addr & mask_tbl[i]) == base_tbl[i]; when several
// entries overlap the lowest index wins.
// Ports:
//   addr     in  32            address to decode
//   base_tbl in  NUM_SLAVES*32 flattened base addresses
//   mask_tbl in  NUM_SLAVES*32 flattened match masks
//   hit_vec  out NUM_SLAVES    one-hot winning slave (all zero on miss)
//   hit      out 1             some slave matched
//   hit_idx  out IDX_W         encoded winning slave index (0 on miss)
module periph_addr_decode
  import periph_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  localparam int IDX_W     = idx_width(NUM_SLAVES)
) (
  input  logic [31:0]              addr,
  input  logic [NUM_SLAVES*32-1:0] base_tbl,
  input  logic [NUM_SLAVES*32-1:0] mask_tbl,
  output logic [NUM_SLAVES-1:0]    hit_vec,
  output logic                     hit,
  output logic [IDX_W-1:0]         hit_idx
);

  // Scan from the highest index down so a lower-index match overwrites.
  always_comb begin
    hit_vec = '0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & mask_tbl[32*i +: 32]) == base_tbl[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
        hit_vec = NUM_SLAVES'(1) << i;
      end
    end
  end

endmodule

// File: rtl/periph_bus_fabric.sv
// Memory-mapped interconnect between the RV32I data port and NUM_SLAVES
// peripherals: table-driven decode, registered chip selects/strobes,
// per-slave ready (wait states), timeout and bus-error response.
// Optional error log: define PERIPH_BUS_FABRIC_ERR_LOG_EN to enable
// err_addr/err_irq; otherwise both read as constant zero.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   m_addr/m_we/m_re/m_be/m_wdata master request (held until m_ready)
//   m_rdata/m_ready/m_err         response, valid in the m_ready cycle
//   s_cs_n/s_rd_n/s_wr_n          registered chip selects and strobes
//   s_addr/s_be/s_wdata           latched request fields
//   s_rdata/s_ready               flattened slave read data, slave ready
//   err_addr/err_irq/err_clr      error log and sticky interrupt
module periph_bus_fabric
  import periph_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES           = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE   = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK   = DEF_SLAVE_MASK,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_RDMASK = {NUM_SLAVES{32'hFFFF_FFFF}},
  parameter int unsigned TIMEOUT_CYCLES       = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              m_addr,
  input  logic                     m_we,
  input  logic                     m_re,
  input  logic [3:0]               m_be,
  input  logic [31:0]              m_wdata,
  output logic [31:0]              m_rdata,
  output logic                     m_ready,
  output logic                     m_err,
  output logic [NUM_SLAVES-1:0]    s_cs_n,
  output logic                     s_rd_n,
  output logic                     s_wr_n,
  output logic [31:0]              s_addr,
  output logic [3:0]               s_be,
  output logic [31:0]              s_wdata,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output logic [31:0]              err_addr,
  output logic                     err_irq,
  input  logic                     err_clr
);

  localparam int IDX_W = idx_width(int'(NUM_SLAVES));
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  bus_state_e              state_q, state_d;
  logic [31:0]             addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]              be_q, be_d;
  logic [IDX_W-1:0]        sel_q, sel_d;
  logic [NUM_SLAVES-1:0]   cs_n_q, cs_n_d;
  logic                    rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic                    ready_q, ready_d, err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0]   hit_vec;
  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic [31:0]             sel_rdata;
  logic                    sel_ready;
  logic                    timeout_hit;
  logic                    log_err;
  logic [31:0]             log_addr;

  periph_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_decode (
    .addr     (m_addr),
    .base_tbl (SLAVE_BASE),
    .mask_tbl (SLAVE_MASK),
    .hit_vec  (hit_vec),
    .hit      (hit),
    .hit_idx  (hit_idx)
  );

  // Only the latched slave's ready and (lane-masked) read data are seen.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_rdata = s_rdata[32*i +: 32] & SLAVE_RDMASK[32*i +: 32];
        sel_ready = s_ready[i];
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    cs_n_d   = cs_n_q;
    rd_n_d   = rd_n_q;
    wr_n_d   = wr_n_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    log_err  = 1'b0;
    log_addr = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m_re || m_we) begin
          addr_d  = m_addr;
          be_d    = m_be;
          wdata_d = m_wdata;
          sel_d   = hit_idx;
          if (hit && (m_re ^ m_we)) begin
            state_d = ST_ACCESS;
            cs_n_d  = ~hit_vec;
            rd_n_d  = ~m_re;
            wr_n_d  = ~m_we;
          end else begin
            // Decode error: answer directly, never touch a chip select.
            state_d  = ST_RESP;
            ready_d  = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
            log_err  = 1'b1;
            log_addr = m_addr;
          end
        end
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = rd_n_q ? 32'h0 : sel_rdata;
          cs_n_d  = '1;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          cs_n_d  = '1;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          log_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cs_n_q  <= '1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_rdata = rdata_q;
  assign m_ready = ready_q;
  assign m_err   = err_q;
  assign s_cs_n  = cs_n_q;
  assign s_rd_n  = rd_n_q;
  assign s_wr_n  = wr_n_q;
  assign s_addr  = addr_q;
  assign s_be    = be_q;
  assign s_wdata = wdata_q;

`ifdef PERIPH_BUS_FABRIC_ERR_LOG_EN
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_irq_q, err_irq_d;

  // A new error in the same cycle as err_clr keeps the interrupt set.
  always_comb begin
    err_addr_d = err_addr_q;
    err_irq_d  = err_irq_q;
    if (err_clr) err_irq_d = 1'b0;
    if (log_err) begin
      err_addr_d = log_addr;
      err_irq_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_addr_q <= '0;
      err_irq_q  <= 1'b0;
    end else begin
      err_addr_q <= err_addr_d;
      err_irq_q  <= err_irq_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_irq  = err_irq_q;
`else
  logic unused_err_log;
  assign unused_err_log = ^{err_clr, log_err, log_addr};
  assign err_addr = '0;
  assign err_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_periph_bus_fabric.sv
module tb_periph_bus_fabric;
  import periph_bus_pkg::*;

  localparam int NS = 4;
  localparam int TO = 4;
  localparam logic [NS*32-1:0] BASES  = {32'h0000_0000, 32'hFFFF_2000, 32'hFFFF_1000, 32'hFFFF_0000};
  localparam logic [NS*32-1:0] MASKS  = {32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
  localparam logic [NS*32-1:0] RDMASK = {32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  logic             clk = 1'b0;
  logic             reset_n;
  logic [31:0]      m_addr, m_wdata, m_rdata, s_addr, s_wdata, err_addr;
  logic             m_we, m_re, m_ready, m_err, s_rd_n, s_wr_n, err_irq, err_clr;
  logic [3:0]       m_be, s_be;
  logic [NS-1:0]    s_cs_n, s_ready;
  logic [NS*32-1:0] s_rdata;

  logic [31:0] srd [NS];
  int          cur_wait = 0;
  int          acc_cnt  = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] exp_eaddr = 32'h0;
  logic        exp_irq   = 1'b0;

  periph_bus_fabric #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     (BASES),
    .SLAVE_MASK     (MASKS),
    .SLAVE_RDMASK   (RDMASK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .m_addr   (m_addr),
    .m_we     (m_we),
    .m_re     (m_re),
    .m_be     (m_be),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .m_err    (m_err),
    .s_cs_n   (s_cs_n),
    .s_rd_n   (s_rd_n),
    .s_wr_n   (s_wr_n),
    .s_addr   (s_addr),
    .s_be     (s_be),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .err_addr (err_addr),
    .err_irq  (err_irq),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  assign s_rdata = {srd[3], srd[2], srd[1], srd[0]};

  // Slave side: a selected slave answers after cur_wait cycles of being
  // selected; every other ready line carries random noise.
  always @(negedge clk) begin
    logic [NS-1:0] r;
    if (s_cs_n != '1) acc_cnt = acc_cnt + 1;
    else              acc_cnt = 0;
    r = NS'($urandom);
    for (int i = 0; i < NS; i++)
      if (!s_cs_n[i]) r[i] = (acc_cnt > cur_wait);
    s_ready = r;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int find_slave(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASKS[32*i +: 32]) == BASES[32*i +: 32]) return i;
    return -1;
  endfunction

  task automatic check_log();
`ifdef PERIPH_BUS_FABRIC_ERR_LOG_EN
    check("err_addr", err_addr, exp_eaddr);
    check("err_irq", {31'h0, err_irq}, {31'h0, exp_irq});
`else
    check("err_addr", err_addr, 32'h0);
    check("err_irq", {31'h0, err_irq}, 32'h0);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs_n"}, {28'h0, s_cs_n}, {28'h0, {NS{1'b1}}});
    check({tag, "_rd_n"}, {31'h0, s_rd_n}, 32'h1);
    check({tag, "_wr_n"}, {31'h0, s_wr_n}, 32'h1);
  endtask

  // One complete master transfer, starting right after a falling edge.
  task automatic xfer(input logic [31:0] addr, input logic re, input logic we,
                      input logic [3:0] be, input logic [31:0] wdata,
                      input int w, input logic clr);
    int          idx, acc, lat, k;
    logic        dec_err, ok, got_ready;
    logic [31:0] exp_rd;
    idx     = find_slave(addr);
    dec_err = (idx < 0) || (re && we);
    ok      = !dec_err && (w <= TO);
    acc     = dec_err ? 0 : ((w <= TO) ? w + 1 : TO + 1);
    lat     = acc + 1;
    exp_rd  = (ok && re) ? (srd[idx] & RDMASK[32*idx +: 32]) : 32'h0;
    cur_wait = w;
    m_addr = addr; m_re = re; m_we = we; m_be = be; m_wdata = wdata; err_clr = clr;
    got_ready = 1'b0;
    k = 0;
    while (!got_ready && k < 40) begin
      @(negedge clk);
      k++;
      if (m_ready) begin
        got_ready = 1'b1;
      end else begin
        if (k <= acc) begin
          check("cs_n", {28'h0, s_cs_n}, {28'h0, ~(NS'(1) << idx)});
          check("rd_n", {31'h0, s_rd_n}, {31'h0, ~re});
          check("wr_n", {31'h0, s_wr_n}, {31'h0, ~we});
          check("s_addr", s_addr, addr);
          check("s_be", {28'h0, s_be}, {28'h0, be});
          check("s_wdata", s_wdata, wdata);
        end else begin
          check_idle_outputs("nosel");
        end
        // Request fields change while busy; the latched copies must not.
        m_addr = $urandom; m_be = 4'($urandom); m_wdata = $urandom;
      end
    end
    check("timeout_wait", {31'h0, got_ready}, 32'h1);
    check("latency", k, lat);
    check("m_err", {31'h0, m_err}, {31'h0, !ok});
    check("m_rdata", m_rdata, exp_rd);
    check_idle_outputs("resp");
    if (!ok) begin
      exp_eaddr = addr;
      exp_irq   = 1'b1;
    end else if (clr) begin
      exp_irq = 1'b0;
    end
    check_log();
    m_re = 1'b0; m_we = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    check("pulse", {31'h0, m_ready}, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr(input int cls);
    logic [31:0] r;
    r = $urandom;
    case (cls)
      0: return {20'hFFFF0, r[11:0]};
      1: return {20'hFFFF1, r[11:0]};
      2: return {20'hFFFF2, r[11:0]};
      3: return {19'h0, r[12:0]};
      4: return {20'hFFFF3, r[11:0]};
      default: return {1'b1, 3'b000, r[27:0]};
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; m_addr = '0; m_we = 0; m_re = 0; m_be = '0; m_wdata = '0; err_clr = 0;
    for (int i = 0; i < NS; i++) srd[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", m_rdata, 32'h0);
    check("rst_ready", {31'h0, m_ready}, 32'h0);
    check("rst_err", {31'h0, m_err}, 32'h0);
    check("rst_saddr", s_addr, 32'h0);
    check("rst_sbe", {28'h0, s_be}, 32'h0);
    check("rst_swdata", s_wdata, 32'h0);
    check_idle_outputs("rst");
    check_log();
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    srd[1] = 32'hDEADBEEF;
    xfer(32'hFFFF_1004, 1'b1, 1'b0, 4'hF, 32'h0, 0, 1'b0);
    srd[2] = 32'h1234_56A5;
    xfer(32'hFFFF_2000, 1'b1, 1'b0, 4'hF, 32'h0, 1, 1'b0);
    xfer(32'h0000_0100, 1'b0, 1'b1, 4'b0011, 32'hCAFE_F00D, 3, 1'b0);
    xfer(32'h8000_0000, 1'b1, 1'b0, 4'hF, 32'h0, 0, 1'b0);
    xfer(32'hFFFF_0008, 1'b1, 1'b0, 4'hF, 32'h0, 100, 1'b0);
    xfer(32'hFFFF_0010, 1'b1, 1'b0, 4'hF, 32'h0, TO, 1'b0);
    xfer(32'hFFFF_1000, 1'b1, 1'b1, 4'hF, 32'h5555_AAAA, 0, 1'b0);
    xfer(32'hFFFF_0000, 1'b1, 1'b0, 4'hF, 32'h0, 0, 1'b1);
    xfer(32'h0000_2000, 1'b1, 1'b0, 4'hF, 32'h0, 0, 1'b1);

    // Reset in the middle of an access.
    cur_wait = 20;
    m_addr = 32'hFFFF_1000; m_re = 1'b1; m_we = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_rdata", m_rdata, 32'h0);
    check("arst_ready", {31'h0, m_ready}, 32'h0);
    check("arst_saddr", s_addr, 32'h0);
    check_idle_outputs("arst");
    exp_eaddr = 32'h0; exp_irq = 1'b0;
    check_log();
    m_re = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("arst_noready", {31'h0, m_ready}, 32'h0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    srd[1] = 32'h0BAD_F00D;
    xfer(32'hFFFF_1FFC, 1'b1, 1'b0, 4'hF, 32'h0, 2, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      int          cls, w;
      logic        re, we, both;
      for (int i = 0; i < NS; i++) srd[i] = $urandom;
      cls  = $urandom_range(0, 5);
      both = ($urandom_range(0, 9) == 0);
      re   = both ? 1'b1 : 1'($urandom);
      we   = both ? 1'b1 : ~re;
      w    = ($urandom_range(0, 7) == 0) ? $urandom_range(TO + 1, 9) : $urandom_range(0, TO);
      xfer(rand_addr(cls), re, we, 4'($urandom), $urandom, w, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
